// File: rtl/hazard_pkg.sv
// Shared types and constants for the decode-stage hazard controller.
// Build option: HAZARD_FWD_EN enables the EX/MEM/WB operand-forwarding paths.
// Without it, every scoreboard match stalls decode until the writer has retired.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  // Stage index order used everywhere: bit 0 = EX, bit 1 = MEM, bit 2 = WB.
`ifdef HAZARD_FWD_EN
  localparam logic [2:0] FWD_PATH = 3'b111;
`else
  localparam logic [2:0] FWD_PATH = 3'b000;
`endif

  // Stages where a load's data is not yet available to forward.
  localparam logic [2:0] LOAD_LATE = 3'b001;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wen;
    logic       is_load;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '0;

  function automatic logic sb_writes(input sb_entry_t e, input logic [4:0] rs);
    return e.valid & e.wen & (e.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side signal bundle of the hazard controller.
// master: decode stage (drives i_*), slave: hazard_ctrl (drives o_*).
interface hazard_ctrl_if;
  logic       i_id_valid;
  logic [4:0] i_id_rs1;
  logic [4:0] i_id_rs2;
  logic       i_id_use_rs1;
  logic       i_id_use_rs2;
  logic [4:0] i_id_rd;
  logic       i_id_rd_wen;
  logic       i_id_is_load;
  logic       i_id_halt;
  logic       i_ex_redirect;
  logic       o_stall_if;
  logic       o_stall_id;
  logic       o_flush_id;
  logic       o_bubble_ex;
  logic [1:0] o_fwd_a_sel;
  logic [1:0] o_fwd_b_sel;
  logic       o_halted;

  modport master (
    output i_id_valid, i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
           i_id_rd, i_id_rd_wen, i_id_is_load, i_id_halt, i_ex_redirect,
    input  o_stall_if, o_stall_id, o_flush_id, o_bubble_ex,
           o_fwd_a_sel, o_fwd_b_sel, o_halted
  );

  modport slave (
    input  i_id_valid, i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
           i_id_rd, i_id_rd_wen, i_id_is_load, i_id_halt, i_ex_redirect,
    output o_stall_if, o_stall_id, o_flush_id, o_bubble_ex,
           o_fwd_a_sel, o_fwd_b_sel, o_halted
  );
endinterface

// File: rtl/hazard_ctrl_fwd_match.sv
// Compares one source register against the EX/MEM/WB scoreboard entries.
// match: stages that hit but cannot be covered by forwarding (decode must stall).
// sel:   youngest forwardable producer, or the register file.
module fwd_match
  import hazard_pkg::*;
(
  input  logic            [4:0] rs,
  input  logic                  use_rs,
  input  sb_entry_t       [2:0] sb,
  output logic            [2:0] match,
  output logic            [1:0] sel
);

  logic [2:0] hit;
  logic [2:0] fwd_ok;

  // Per-stage hit, and whether that hit can be served by a forward path.
  always_comb begin
    hit    = '0;
    fwd_ok = '0;
    for (int i = 0; i < 3; i++) begin
      hit[i]    = use_rs & (rs != 5'd0) & sb_writes(sb[i], rs);
      fwd_ok[i] = hit[i] & FWD_PATH[i] & ~(sb[i].is_load & LOAD_LATE[i]);
    end
  end

  assign match = hit & ~fwd_ok;

  // Youngest forwardable stage wins.
  always_comb begin
    sel = FWD_RF;
    if (fwd_ok[0])      sel = FWD_EX;
    else if (fwd_ok[1]) sel = FWD_MEM;
    else if (fwd_ok[2]) sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: scoreboard of in-flight writers (EX/MEM/WB),
// stall/flush/bubble generation, forward selects and halt draining.
// Build option: HAZARD_FWD_EN (see hazard_pkg) selects forwarding vs. stall-only.
//
// state  | meaning
// RUN    | normal operation, hazards resolved by forward or stall
// DRAIN  | halt accepted; front end frozen until the halt leaves WB
// HALTED | pipeline empty, everything held until reset
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  hazard_ctrl_if.slave  hz
);

  state_t          state, state_nxt;
  sb_entry_t [2:0] sb;
  sb_entry_t       id_entry;
  logic [2:0]      blk_a, blk_b;
  logic [1:0]      sel_a, sel_b;
  logic            hazard;
  logic            stall_if, stall_id, flush_id, bubble_ex, halted;
  logic [1:0]      fwd_a, fwd_b;

  fwd_match u_fwd_a (
    .rs     (hz.i_id_rs1),
    .use_rs (hz.i_id_valid & hz.i_id_use_rs1),
    .sb     (sb),
    .match  (blk_a),
    .sel    (sel_a)
  );

  fwd_match u_fwd_b (
    .rs     (hz.i_id_rs2),
    .use_rs (hz.i_id_valid & hz.i_id_use_rs2),
    .sb     (sb),
    .match  (blk_b),
    .sel    (sel_b)
  );

  assign hazard = |{blk_a, blk_b};

  assign id_entry = '{valid:   1'b1,
                      rd:      hz.i_id_rd,
                      wen:     hz.i_id_rd_wen,
                      is_load: hz.i_id_is_load};

  // Next-state and hazard outputs; a redirect overrides any stall or halt in ID.
  always_comb begin
    state_nxt = state;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    flush_id  = 1'b0;
    bubble_ex = 1'b0;
    halted    = 1'b0;
    fwd_a     = FWD_RF;
    fwd_b     = FWD_RF;
    case (state)
      RUN: begin
        fwd_a = sel_a;
        fwd_b = sel_b;
        if (hz.i_ex_redirect) begin
          flush_id  = 1'b1;
          bubble_ex = 1'b1;
        end else if (hazard) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          bubble_ex = 1'b1;
        end else if (hz.i_id_valid && hz.i_id_halt) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        stall_if  = 1'b1;
        flush_id  = 1'b1;
        bubble_ex = 1'b1;
        // Halt is the youngest entry; once it sits in WB the next edge empties the pipe.
        if (!sb[0].valid && !sb[1].valid) state_nxt = HALTED;
      end
      HALTED: begin
        halted    = 1'b1;
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign hz.o_stall_if  = stall_if;
  assign hz.o_stall_id  = stall_id;
  assign hz.o_flush_id  = flush_id;
  assign hz.o_bubble_ex = bubble_ex;
  assign hz.o_fwd_a_sel = fwd_a;
  assign hz.o_fwd_b_sel = fwd_b;
  assign hz.o_halted    = halted;

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= RUN;
    else        state <= state_nxt;
  end

  // Scoreboard shift: decode entry into EX unless bubbled or empty.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sb <= {SB_EMPTY, SB_EMPTY, SB_EMPTY};
    end else begin
      sb[0] <= (bubble_ex || !hz.i_id_valid) ? SB_EMPTY : id_entry;
      sb[1] <= sb[0];
      sb[2] <= sb[1];
    end
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller that sequences the instruction-decode stage of the RV32I core. It tracks in-flight register writes in a three-entry scoreboard (EX, MEM, WB) and drives stall, flush and operand-forward selects for the decode/execute boundary. It also drains the pipeline when a halt instruction retires from decode. It sits beside the decode stage, takes decoded register addresses and control bits, and gates the IF/ID and ID/EX pipeline registers.

## Interface
Parameters:
- none. Register address width is fixed at 5 bits and pipeline depth at 3 tracked stages.

Ports:
- i_clk  in  1  core clock, rising edge
- i_rst  in  1  asynchronous, active-low reset
- i_id_valid  in  1  decode stage holds a valid instruction
- i_id_rs1  in  5  decode rs1 address
- i_id_rs2  in  5  decode rs2 address
- i_id_use_rs1  in  1  instruction reads rs1
- i_id_use_rs2  in  1  instruction reads rs2
- i_id_rd  in  5  decode destination address
- i_id_rd_wen  in  1  instruction writes rd
- i_id_is_load  in  1  instruction is a load (dmem read)
- i_id_halt  in  1  instruction is the halt
- i_ex_redirect  in  1  branch taken or jump resolved in EX
- o_stall_if  out  1  hold PC and IF/ID register
- o_stall_id  out  1  hold the decode instruction
- o_flush_id  out  1  clear the IF/ID register to a bubble
- o_bubble_ex  out  1  load a bubble into ID/EX
- o_fwd_a_sel  out  2  rs1 operand source: 00 regfile, 01 EX, 10 MEM, 11 WB
- o_fwd_b_sel  out  2  rs2 operand source, same encoding
- o_halted  out  1  pipeline drained after halt; sticky until reset

## Operation
- Scoreboard entry: {valid, rd, wen, is_load}. Each cycle WB<=MEM, MEM<=EX, EX<=ID entry. EX takes an invalid entry when o_bubble_ex=1 or i_id_valid=0.
- Match(rs, stage): stage.valid & stage.wen & stage.rd==rs & rs!=0 & use_rs.
- Forward select priority is youngest first: EX (non-load) 01, then MEM 10, then WB 11, else 00.
- Load-use: a match against EX where EX.is_load=1 asserts o_stall_if, o_stall_id and o_bubble_ex for exactly one cycle. The next cycle the load is in MEM and forward select 10 applies.
- Redirect: i_ex_redirect=1 asserts o_flush_id and o_bubble_ex and deasserts both stalls. Redirect overrides load-use.
- FSM states:
  - RUN: normal operation.
  - RUN to DRAIN: i_id_valid & i_id_halt, not stalled, no redirect, so the halt advances into EX.
  - DRAIN: o_stall_if=1 and o_flush_id=1 every cycle, and no new instructions enter. Go to HALTED when EX, MEM and WB are all invalid or the halt entry has left WB. This takes 3 cycles after entry.
  - HALTED: o_halted=1, all stalls held at 1, forward selects 00. Leaves only on reset.
- A halt in decode that is flushed by a redirect does not leave RUN.
- Reset mid-operation clears the scoreboard, sets state RUN and drives all outputs to 0. This holds in any state.

## Timing
- Stall, flush, bubble and forward outputs are combinational from the scoreboard registers and the ID inputs, valid within the same cycle. State and scoreboard update on the rising edge.
- Load-use penalty is exactly 1 cycle. Redirect penalty is 2 cycles (IF and ID squashed).
- Reset values: every output 0, state RUN, all entries invalid.
- Simultaneous load-use and redirect: redirect wins, and no stall is asserted.
- Simultaneous halt in ID and redirect: the flush wins, and the halt is discarded.

## Configuration
- HAZARD_FWD_EN defined: forwarding paths are enabled as described.
- Without the macro:
  - o_fwd_a_sel and o_fwd_b_sel are tied to 00.
  - Any match against EX, MEM or WB stalls (o_stall_if, o_stall_id, o_bubble_ex) until no match remains. This takes up to 3 cycles.
  - The register file is not write-through.

## Structure
- Package hazard_pkg holds:
  - forward-select encodings FWD_RF, FWD_EX, FWD_MEM, FWD_WB
  - FSM state enum (RUN, DRAIN, HALTED)
  - scoreboard entry struct
- One sub-module, fwd_match: it compares one rs against the three entries and returns the match vector and the prioritized select. It is instantiated twice, for rs1 and rs2.

## Test plan
- addi x5 then add x6,x5,x5 back-to-back -> o_fwd_a_sel=o_fwd_b_sel=01, no stall.
- lw x7 then add x8,x7,x0 -> one cycle of o_stall_if=o_stall_id=o_bubble_ex=1, then o_fwd_a_sel=10.
- Writer to x0 followed by a reader of x0 -> selects 00, no stall.
- lw x9 in EX with a dependent op in ID and i_ex_redirect=1 the same cycle -> o_flush_id=1, o_bubble_ex=1, stalls 0.
- Halt in ID with no hazards -> DRAIN for 3 cycles, then o_halted=1. Pulse reset low mid-DRAIN -> all outputs 0 and state RUN.
- Without HAZARD_FWD_EN: addi x5 then add x6,x5,x0 -> stall for 3 cycles, selects stay 00.
